// File: rtl/loader_pkg.sv
// loader_pkg: FSM state type, default geometry and derived-size helpers
// shared by the stream key loader and its beat packer.
package loader_pkg;
    typedef enum logic [1:0] {S_KEY, S_PT, S_DONE} state_t;
    localparam int DEF_DIN_W   = 4;
    localparam int DEF_BLOCK_W = 128;
    localparam int BEATS       = DEF_BLOCK_W / DEF_DIN_W;
    localparam int BEAT_CNT_W  = $clog2(BEATS);
    function automatic int beats_of(input int din_w, input int block_w);
        return block_w / din_w;
    endfunction
    function automatic int cnt_w_of(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic bit cfg_ok(input int din_w, input int block_w, input int num_rk, input int addr_w);
        return din_w > 0 && block_w % din_w == 0 && num_rk > 0 && num_rk <= 2 ** addr_w;
    endfunction
endpackage

// File: rtl/stream_key_loader_if.sv
// stream_key_loader_if: host beat stream in, key RAM write port and
// plaintext/status out.
interface stream_key_loader_if
    import loader_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int ADDR_W  = 4
);
    logic               wr_en;
    logic [DIN_W-1:0]   wr_data;
    logic               restart;
    logic               keep_key;
    logic               ks_we;
    logic [ADDR_W-1:0]  ks_addr;
    logic [BLOCK_W-1:0] ks_wdata;
    logic [BLOCK_W-1:0] pt;
    logic               key_valid;
    logic               pt_valid;
    logic               overflow;
    modport slave (
        input  wr_en, wr_data, restart, keep_key,
        output ks_we, ks_addr, ks_wdata, pt, key_valid, pt_valid, overflow
    );
    modport master (
        output wr_en, wr_data, restart, keep_key,
        input  ks_we, ks_addr, ks_wdata, pt, key_valid, pt_valid, overflow
    );
endinterface

// File: rtl/beat_packer.sv
// beat_packer: inserts DIN_W beats LSB-first into a BLOCK_W word; word
// presents the word including the current beat, word_done marks its last beat.
module beat_packer
    import loader_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_valid,
    input  logic [DIN_W-1:0]   i_data,
    input  logic               flush,
    output logic [BLOCK_W-1:0] word,
    output logic               word_done
);
    localparam int NB = beats_of(DIN_W, BLOCK_W);
    localparam int CW = cnt_w_of(NB);
    logic [CW-1:0]      r_cnt;
    logic [BLOCK_W-1:0] r_word;
    logic               w_take;
    assign w_take    = i_valid && !flush;
    assign word_done = w_take && r_cnt == CW'(NB - 1);
    always_comb begin
        word = r_word;
        word[r_cnt*DIN_W +: DIN_W] = i_data;
    end
    // stale upper bits are left in place: every word is fully overwritten before use
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (i_valid) begin
            r_word <= word;
            r_cnt  <= word_done ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/stream_key_loader.sv
// stream_key_loader: packs host beats into NUM_RK round-key RAM writes, then
// one plaintext block; supports restart with optional key retention.
module stream_key_loader
    import loader_pkg::*;
#(
    parameter int DIN_W   = DEF_DIN_W,
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int NUM_RK  = 11,
    parameter int ADDR_W  = 4
) (
    input logic                clk,
    input logic                rstn,
    stream_key_loader_if.slave bus
);
    if (!cfg_ok(DIN_W, BLOCK_W, NUM_RK, ADDR_W)) begin : g_cfg_err
        $error("stream_key_loader: BLOCK_W must be a multiple of DIN_W and NUM_RK <= 2**ADDR_W");
    end
    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_widx;
    logic               r_ks_we;
    logic [ADDR_W-1:0]  r_ks_addr;
    logic [BLOCK_W-1:0] r_ks_wdata;
    logic [BLOCK_W-1:0] r_pt;
    logic               r_key_valid;
    logic               r_pt_valid;
    logic               r_overflow;
    logic [BLOCK_W-1:0] w_word;
    logic               w_done;
    logic               w_in;
    logic               w_key_last;
    logic               w_key_wr;
    logic               w_pt_wr;
    assign w_in       = bus.wr_en && r_state != S_DONE;
    assign w_key_last = r_widx == ADDR_W'(NUM_RK - 1);
    assign w_key_wr   = w_done && r_state == S_KEY;
    assign w_pt_wr    = w_in && !bus.restart && r_state == S_PT;
    beat_packer #(.DIN_W(DIN_W), .BLOCK_W(BLOCK_W)) u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .i_valid   (w_in),
        .i_data    (bus.wr_data),
        .flush     (bus.restart),
        .word      (w_word),
        .word_done (w_done)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_KEY;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = bus.restart ? ((bus.keep_key && r_key_valid) ? S_PT : S_KEY)
                    : (w_key_wr && w_key_last) ? S_PT
                    : (w_done && r_state == S_PT) ? S_DONE
                    : r_state;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_widx      <= '0;
            r_ks_we     <= 1'b0;
            r_ks_addr   <= '0;
            r_ks_wdata  <= '0;
            r_pt        <= '0;
            r_key_valid <= 1'b0;
            r_pt_valid  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_ks_we <= w_key_wr;
            r_widx  <= bus.restart ? '0 : w_key_wr ? (w_key_last ? '0 : r_widx + 1'b1) : r_widx;
            if (w_key_wr) begin
                r_ks_addr  <= r_widx;
                r_ks_wdata <= w_word;
            end
            if (w_pt_wr) r_pt <= w_word;
            r_key_valid <= bus.restart ? (bus.keep_key && r_key_valid) : (r_key_valid || (w_key_wr && w_key_last));
            r_pt_valid  <= !bus.restart && (r_pt_valid || (w_done && r_state == S_PT));
            r_overflow  <= !bus.restart && (r_overflow || (bus.wr_en && r_state == S_DONE));
        end
    end
    assign bus.ks_we     = r_ks_we;
    assign bus.ks_addr   = r_ks_addr;
    assign bus.ks_wdata  = r_ks_wdata;
    assign bus.pt        = r_pt;
    assign bus.key_valid = r_key_valid;
    assign bus.pt_valid  = r_pt_valid;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_stream_key_loader.sv
// tb_stream_key_loader: directed/randomized load sequences on two geometries,
// checked against a beat-queue reference model.
module tb_stream_key_loader;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    stream_key_loader_if #(.DIN_W(4), .BLOCK_W(128), .ADDR_W(4)) ifa ();
    stream_key_loader_if #(.DIN_W(8), .BLOCK_W(64), .ADDR_W(2)) ifb ();

    stream_key_loader #(.DIN_W(4), .BLOCK_W(128), .NUM_RK(11), .ADDR_W(4)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ifa));
    stream_key_loader #(.DIN_W(8), .BLOCK_W(64), .NUM_RK(4), .ADDR_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ifb));

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [3:0]   wa_addr[$];
    logic [127:0] wa_data[$];
    logic [1:0]   wb_addr[$];
    logic [63:0]  wb_data[$];
    logic [3:0]   bq[$];
    logic [7:0]   bqb[$];

    always @(negedge clk) begin
        if (ifa.ks_we === 1'b1) begin
            wa_addr.push_back(ifa.ks_addr);
            wa_data.push_back(ifa.ks_wdata);
        end
        if (ifb.ks_we === 1'b1) begin
            wb_addr.push_back(ifb.ks_addr);
            wb_data.push_back(ifb.ks_wdata);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_word_a(input int w);
        logic [127:0] r = '0;
        for (int k = 0; k < 32; k++) r |= 128'(bq[w*32+k]) << (4 * k);
        return r;
    endfunction

    function automatic logic [63:0] exp_word_b(input int w);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r |= 64'(bqb[w*8+k]) << (8 * k);
        return r;
    endfunction

    task automatic send_a(input logic [3:0] d, input bit gap);
        ifa.wr_en = 1'b1;
        ifa.wr_data = d;
        @(negedge clk);
        ifa.wr_en = 1'b0;
        if (gap) repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d);
        ifb.wr_en = 1'b1;
        ifb.wr_data = d;
        @(negedge clk);
        ifb.wr_en = 1'b0;
    endtask

    task automatic load_key_a(input bit rnd, input bit gaps);
        logic [3:0] d;
        bq.delete();
        for (int i = 0; i < 352; i++) begin
            d = rnd ? 4'($urandom) : 4'(i % 16);
            bq.push_back(d);
            send_a(d, gaps && i != 351 && $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic restart_a(input bit keep, input bit with_beat);
        ifa.restart = 1'b1;
        ifa.keep_key = keep;
        ifa.wr_en = with_beat;
        ifa.wr_data = 4'hF;
        @(negedge clk);
        ifa.restart = 1'b0;
        ifa.keep_key = 1'b0;
        ifa.wr_en = 1'b0;
    endtask

    task automatic check_writes_a(input string tag, input int n);
        chk({tag, "_nwrites"}, 128'(wa_data.size()), 128'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), i < wa_addr.size() ? 128'(wa_addr[i]) : 'x, 128'(i));
            chk($sformatf("%s_data%0d", tag, i), i < wa_data.size() ? wa_data[i] : 'x, exp_word_a(i));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ept;
        logic [63:0]  eptb;
        logic [3:0]   d;
        logic [7:0]   db;
        rstn = 1'b0;
        ifa.wr_en = 1'b0; ifa.wr_data = '0; ifa.restart = 1'b0; ifa.keep_key = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_data = '0; ifb.restart = 1'b0; ifb.keep_key = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ks_we", 128'(ifa.ks_we), 0);
        chk("rst_key_valid", 128'(ifa.key_valid), 0);
        chk("rst_pt_valid", 128'(ifa.pt_valid), 0);
        chk("rst_overflow", 128'(ifa.overflow), 0);
        chk("rst_ks_addr", 128'(ifa.ks_addr), 0);
        chk("rst_ks_wdata", ifa.ks_wdata, 0);
        chk("rst_pt", ifa.pt, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Full load: index-pattern key then all-A plaintext
        load_key_a(1'b0, 1'b0);
        chk("t1_ks_we_latency", 128'(ifa.ks_we), 1);
        chk("t1_key_valid_with_last_we", 128'(ifa.key_valid), 1);
        chk("t1_last_addr", 128'(ifa.ks_addr), 10);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("t1_pt_valid_early", 128'(ifa.pt_valid), 0);
            send_a(4'hA, 1'b0);
        end
        chk("t1_pt_valid", 128'(ifa.pt_valid), 1);
        chk("t1_pt", ifa.pt, {32{4'hA}});
        chk("t1_word0", wa_data.size() > 0 ? wa_data[0] : 'x, 128'hFEDCBA9876543210FEDCBA9876543210);
        check_writes_a("t1", 11);

        // Extra beat after completion
        send_a(4'h3, 1'b0);
        chk("t2_overflow", 128'(ifa.overflow), 1);
        chk("t2_pt_held", ifa.pt, {32{4'hA}});
        chk("t2_pt_valid_held", 128'(ifa.pt_valid), 1);

        // Keep-key restart, new plaintext only
        wa_addr.delete(); wa_data.delete();
        restart_a(1'b1, 1'b0);
        chk("t3_pt_valid_clr", 128'(ifa.pt_valid), 0);
        chk("t3_overflow_clr", 128'(ifa.overflow), 0);
        chk("t3_key_valid_kept", 128'(ifa.key_valid), 1);
        for (int i = 0; i < 32; i++) send_a(4'h5, $urandom_range(0, 3) == 0);
        @(negedge clk);
        chk("t3_pt", ifa.pt, {32{4'h5}});
        chk("t3_pt_valid", 128'(ifa.pt_valid), 1);
        chk("t3_no_writes", 128'(wa_data.size()), 0);
        chk("t3_key_valid", 128'(ifa.key_valid), 1);

        // Restart mid word 3 with a simultaneous beat, then a fresh random load
        restart_a(1'b0, 1'b0);
        chk("t4_key_valid_clr", 128'(ifa.key_valid), 0);
        wa_addr.delete(); wa_data.delete();
        bq.delete();
        for (int i = 0; i < 116; i++) begin
            d = 4'($urandom);
            bq.push_back(d);
            send_a(d, $urandom_range(0, 3) == 0);
        end
        restart_a(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_writes_a("t4_partial", 3);
        wa_addr.delete(); wa_data.delete();
        load_key_a(1'b1, 1'b1);
        ept = '0;
        for (int k = 0; k < 32; k++) begin
            d = 4'($urandom);
            ept |= 128'(d) << (4 * k);
            send_a(d, $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        check_writes_a("t4", 11);
        chk("t4_pt", ifa.pt, ept);
        chk("t4_pt_valid", 128'(ifa.pt_valid), 1);

        // keep_key without a valid key is a full restart
        restart_a(1'b0, 1'b0);
        restart_a(1'b1, 1'b0);
        chk("t5_key_valid", 128'(ifa.key_valid), 0);
        wa_addr.delete(); wa_data.delete();
        bq.delete();
        for (int i = 0; i < 32; i++) begin
            d = 4'($urandom);
            bq.push_back(d);
            send_a(d, 1'b0);
        end
        @(negedge clk);
        check_writes_a("t5", 1);

        // Asynchronous reset mid-plaintext
        restart_a(1'b0, 1'b0);
        load_key_a(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_a(4'($urandom), 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("t6_ks_we", 128'(ifa.ks_we), 0);
        chk("t6_key_valid", 128'(ifa.key_valid), 0);
        chk("t6_pt", ifa.pt, 0);
        chk("t6_ks_wdata", ifa.ks_wdata, 0);
        chk("t6_ks_addr", 128'(ifa.ks_addr), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Second geometry: 8-bit beats, 64-bit words, 4 keys
        bqb.delete();
        for (int i = 0; i < 32; i++) begin
            db = 8'($urandom);
            bqb.push_back(db);
            send_b(db);
        end
        chk("t7_key_valid", 128'(ifb.key_valid), 1);
        eptb = '0;
        for (int k = 0; k < 8; k++) begin
            db = 8'($urandom);
            eptb |= 64'(db) << (8 * k);
            send_b(db);
        end
        @(negedge clk);
        chk("t7_nwrites", 128'(wb_data.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t7_addr%0d", i), i < wb_addr.size() ? 128'(wb_addr[i]) : 'x, 128'(i));
            chk($sformatf("t7_data%0d", i), i < wb_data.size() ? 128'(wb_data[i]) : 'x, 128'(exp_word_b(i)));
        end
        chk("t7_pt", 128'(ifb.pt), 128'(eptb));
        chk("t7_pt_valid", 128'(ifb.pt_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_key_loader.md
# stream_key_loader

Parametrised loader that converts the narrow host beat stream (`DATA_FEED`/`WRITE` from `host_if`) into full-width round-key words for the `KeySupplier` RAM write port, followed by one plaintext block for the cipher core. It generalises the fixed 4-bit / 128-bit / 11-key loader in the AES top to arbitrary beat width, block width and key count. It adds explicit completion flags, overflow detection, a synchronous restart, and a key-retain mode so that new plaintexts can be loaded without resending the schedule.

## Interface
Parameters:
- `DIN_W`, 4 — beat width in bits.
- `BLOCK_W`, 128 — round-key and plaintext width in bits; must be a multiple of `DIN_W`.
- `NUM_RK`, 11 — number of round-key words loaded before the plaintext.
- `ADDR_W`, 4 — key RAM address width; `NUM_RK <= 2**ADDR_W`.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `wr_en` in 1 — beat valid (host `WRITE`).
- `wr_data` in `DIN_W` — beat data (host `DATA_FEED`).
- `restart` in 1 — synchronous restart of the load sequence.
- `keep_key` in 1 — sampled with `restart`; 1 = skip key phase and load plaintext only.
- `ks_we` out 1 — key RAM write strobe, one-cycle pulse per word.
- `ks_addr` out `ADDR_W` — key RAM write address.
- `ks_wdata` out `BLOCK_W` — key RAM write data.
- `pt` out `BLOCK_W` — assembled plaintext.
- `key_valid` out 1 — all `NUM_RK` words written.
- `pt_valid` out 1 — plaintext complete.
- `overflow` out 1 — sticky; a beat arrived after `pt_valid`.

## Operation
- `BEATS = BLOCK_W/DIN_W`. Beat k of a word (k = 0 .. `BEATS`-1) lands in bits `[(k+1)*DIN_W-1 -: DIN_W]`, i.e. the first beat is the least significant.
- Three-state FSM: `S_KEY`, `S_PT`, `S_DONE`.
- `S_KEY`:
  - Each `wr_en` stores a beat into the assembly register and increments the beat counter.
  - On the beat with k = `BEATS`-1, the next cycle gives `ks_we`=1, `ks_wdata` = the complete word (including that beat), and `ks_addr` = the word index (0 .. `NUM_RK`-1).
  - After word `NUM_RK`-1, set `key_valid` and go to `S_PT`.
  - Back-to-back beats incur no gaps or lost beats.
- `S_PT`:
  - Beats assemble directly into `pt`.
  - On the last beat, set `pt_valid` and go to `S_DONE`.
- `S_DONE`:
  - `wr_en` sets `overflow`.
  - Data is ignored; `pt`, `key_valid` and `pt_valid` are held.
- `restart`:
  - Clears the beat and word counters, `pt_valid` and `overflow`.
  - With `keep_key`=1 and `key_valid`=1: go to `S_PT`, with `key_valid` kept.
  - Otherwise: go to `S_KEY` and clear `key_valid`.
  - `keep_key`=1 while `key_valid`=0 behaves as a full restart.
  - `restart` has priority over a simultaneous `wr_en`; that beat is dropped.
  - `restart` mid-word discards the partial word; no `ks_we` is issued for it.
- Counters are sized `$clog2(BEATS)` and `ADDR_W` and never wrap inside a phase.

## Timing
- Reset (async, `rstn`=0):
  - State becomes `S_KEY`.
  - `ks_we`, `key_valid`, `pt_valid` and `overflow` = 0.
  - `ks_addr`, `ks_wdata` and `pt` = 0.
  - All counters = 0.
- `ks_we` latency: 1 cycle after the completing beat. `ks_addr` and `ks_wdata` are valid only while `ks_we`=1 and are held otherwise.
- `key_valid` rises in the same cycle as the final `ks_we`.
- `pt_valid` rises 1 cycle after the final plaintext beat.
- The first plaintext beat may arrive in the cycle immediately after the final key beat.
- Reset asserted mid-load: all state is lost, and any partial RAM contents are stale until `key_valid`.

## Structure
- Shared package `loader_pkg`:
  - FSM state enum.
  - Derived constants `BEATS` and `BEAT_CNT_W`.
  - An elaboration check for `BLOCK_W % DIN_W == 0` and `NUM_RK <= 2**ADDR_W`.
- Sub-module `beat_packer` (`DIN_W`, `BLOCK_W`):
  - Shift/insert assembly register and beat counter.
  - Outputs `word`, `word_done`, and a `flush` input driven by `restart`.
  - Instantiated once and shared by the key and plaintext phases.

## Test plan
- Defaults; 352 key beats with `wr_data` = beat index mod 16, then 32 plaintext beats of 4'hA:
  - 11 `ks_we` pulses, `ks_addr` 0..10.
  - Word 0 = 128'hFEDCBA9876543210FEDCBA9876543210.
  - `pt` = all-A; `key_valid` then `pt_valid` high.
- After a full load, 1 extra beat -> `overflow`=1 and `pt` unchanged.
- `restart` with `keep_key`=1 after a full load, then 32 beats of 4'h5:
  - No `ks_we`; `key_valid` stays 1.
  - `pt` = all-5; `pt_valid` 0→1.
- `restart` after 20 beats of word 3 -> no write for the partial word. A fresh 352-beat load then writes addresses 0..10 correctly.
- `restart` and `wr_en` in the same cycle -> the beat is dropped and the counters are 0.
- `DIN_W`=8, `BLOCK_W`=64, `NUM_RK`=4, `ADDR_W`=2: 32 key beats then 8 plaintext beats -> 4 writes, `pt_valid` high.
- Also exercise `rstn` asserted mid-plaintext -> all outputs 0 asynchronously.
